// File: rtl/reg_window_ctrl.sv
// Register-window manager: turns CALL/RET into window moves and
// spills/fills low register pairs to a data-memory stack.
module reg_window_ctrl #(
   parameter int                DATA_W     = 16,
   parameter int                ADDR_W     = 8,
   parameter logic [ADDR_W-1:0] SPILL_BASE = 8'h80,
   parameter int                STACK_WIN  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              call_req,
   input  logic              ret_req,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        cwp,
   output logic [1:0]        wnd,
   output logic              set_window,
   output logic [1:0]        rf_ri,
   output logic              rf_we,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int DEPTH_W = $clog2(STACK_WIN + 1);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_WIN);

   typedef enum logic [3:0] {
      S_INIT,
      S_IDLE,
      S_SP_SEL,
      S_SP_W0,
      S_SP_W1,
      S_FL_SEL,
      S_FL_R0,
      S_FL_W0,
      S_FL_R1,
      S_FL_W1,
      S_COMMIT
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          cwp_q, cwp_d;
   logic [1:0]          r_q, r_d;
   logic [ADDR_W-1:0]   sp_q, sp_d;
   logic [DEPTH_W-1:0]  depth_q, depth_d;
   logic                dir_q, dir_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   buf_q, buf_d;

   assign cwp = cwp_q;
   assign err = err_q;

   // State and bookkeeping registers; reset aborts any spill/fill in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_INIT;
         cwp_q   <= 2'd0;
         r_q     <= 2'd1;
         sp_q    <= SPILL_BASE;
         depth_q <= '0;
         dir_q   <= 1'b0;
         err_q   <= 1'b0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         cwp_q   <= cwp_d;
         r_q     <= r_d;
         sp_q    <= sp_d;
         depth_q <= depth_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
         buf_q   <= buf_d;
      end
   end

   // Next-state and output decode for the window/spill/fill sequencer.
   always_comb begin
      state_d    = state_q;
      cwp_d      = cwp_q;
      r_d        = r_q;
      sp_d       = sp_q;
      depth_d    = depth_q;
      dir_d      = dir_q;
      err_d      = 1'b0;
      buf_d      = buf_q;
      busy       = 1'b0;
      done       = 1'b0;
      set_window = 1'b0;
      wnd        = cwp_q;
      rf_ri      = 2'd0;
      rf_we      = 1'b0;
      rf_wdata   = buf_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = sp_q;
      mem_wdata  = rf_rdata;

      unique case (state_q)
         S_INIT: begin
            set_window = 1'b1;
            wnd        = 2'd0;
            state_d    = S_IDLE;
         end
         S_IDLE: begin
            if (call_req) begin
               dir_d = 1'b1;
               if (r_q != 2'd3) begin
                  r_d     = r_q + 2'd1;
                  state_d = S_COMMIT;
               end else if (depth_q != DEPTH_MAX) begin
                  state_d = S_SP_SEL;
               end else begin
                  err_d = 1'b1;
               end
            end else if (ret_req) begin
               dir_d = 1'b0;
               if (r_q != 2'd1) begin
                  r_d     = r_q - 2'd1;
                  state_d = S_COMMIT;
               end else if (depth_q != '0) begin
                  state_d = S_FL_SEL;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_SP_SEL: begin
            busy       = 1'b1;
            set_window = 1'b1;
            wnd        = cwp_q + 2'd2;
            state_d    = S_SP_W0;
         end
         S_SP_W0: begin
            busy     = 1'b1;
            wnd      = cwp_q + 2'd2;
            rf_ri    = 2'd0;
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = sp_q;
            if (mem_ack) state_d = S_SP_W1;
         end
         S_SP_W1: begin
            busy     = 1'b1;
            wnd      = cwp_q + 2'd2;
            rf_ri    = 2'd1;
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = sp_q + ADDR_W'(1);
            if (mem_ack) begin
               sp_d    = sp_q + ADDR_W'(2);
               depth_d = depth_q + DEPTH_W'(1);
               state_d = S_COMMIT;
            end
         end
         S_FL_SEL: begin
            busy       = 1'b1;
            set_window = 1'b1;
            wnd        = cwp_q - 2'd1;
            state_d    = S_FL_R0;
         end
         S_FL_R0: begin
            busy     = 1'b1;
            wnd      = cwp_q - 2'd1;
            rf_ri    = 2'd0;
            mem_req  = 1'b1;
            mem_addr = sp_q - ADDR_W'(2);
            if (mem_ack) begin
               buf_d   = mem_rdata;
               state_d = S_FL_W0;
            end
         end
         S_FL_W0: begin
            busy    = 1'b1;
            wnd     = cwp_q - 2'd1;
            rf_ri   = 2'd0;
            rf_we   = 1'b1;
            state_d = S_FL_R1;
         end
         S_FL_R1: begin
            busy     = 1'b1;
            wnd      = cwp_q - 2'd1;
            rf_ri    = 2'd1;
            mem_req  = 1'b1;
            mem_addr = sp_q - ADDR_W'(1);
            if (mem_ack) begin
               buf_d   = mem_rdata;
               state_d = S_FL_W1;
            end
         end
         S_FL_W1: begin
            busy    = 1'b1;
            wnd     = cwp_q - 2'd1;
            rf_ri   = 2'd1;
            rf_we   = 1'b1;
            sp_d    = sp_q - ADDR_W'(2);
            depth_d = depth_q - DEPTH_W'(1);
            state_d = S_COMMIT;
         end
         S_COMMIT: begin
            busy       = 1'b1;
            set_window = 1'b1;
            done       = 1'b1;
            wnd        = dir_q ? (cwp_q + 2'd1) : (cwp_q - 2'd1);
            cwp_d      = wnd;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Bench for reg_window_ctrl: register-file and memory models plus
// a window/stack reference model driven by directed and random ops.
module tb_reg_window_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        call_req = 1'b0;
   logic        ret_req = 1'b0;
   logic        busy, done, err, set_window, rf_we;
   logic [1:0]  cwp, wnd, rf_ri;
   logic [15:0] rf_wdata, rf_rdata;
   logic        mem_req, mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   reg_window_ctrl dut (
      .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req),
      .busy(busy), .done(done), .err(err), .cwp(cwp), .wnd(wnd),
      .set_window(set_window), .rf_ri(rf_ri), .rf_we(rf_we),
      .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // register file model
   logic [15:0] phys [8];
   logic [1:0]  win;
   logic        sc_en = 1'b0;
   logic [15:0] sc_arr [8];

   assign rf_rdata = phys[(2 * int'(win) + int'(rf_ri)) % 8];

   always @(posedge clk or posedge rst) begin
      if (rst) win = 2'd0;
      else if (set_window) win = wnd;
   end

   always @(negedge clk) begin
      if (sc_en) begin
         for (int i = 0; i < 8; i++) phys[i] = sc_arr[i];
      end else if (rf_we) begin
         phys[(2 * int'(win) + int'(rf_ri)) % 8] = rf_wdata;
      end
   end

   // memory model with programmable ack latency
   logic [15:0] mem [256];
   int          lat = 0;
   int          cnt = 0;
   logic        pend = 1'b0;
   logic        pwe;
   logic [7:0]  paddr;
   logic [15:0] pdata;
   logic        mem_seen;

   always @(posedge clk) begin
      if (!rst && mem_req && mem_ack && mem_we) mem[mem_addr] = mem_wdata;
      if (mem_req) mem_seen = 1'b1;
   end

   always @(negedge clk or posedge rst) begin
      if (rst) begin
         mem_ack = 1'b0;
         cnt = 0;
         pend = 1'b0;
      end else begin
         if (pend && !mem_ack && mem_req) begin
            chk("hold_addr", 32'(mem_addr), 32'(paddr));
            chk("hold_we", 32'(mem_we), 32'(pwe));
            if (pwe) chk("hold_wdata", 32'(mem_wdata), 32'(pdata));
         end
         if (mem_ack) cnt = 0;
         mem_ack = 1'b0;
         if (mem_req) begin
            if (cnt >= lat) begin
               mem_ack = 1'b1;
               mem_rdata = mem[mem_addr];
            end else begin
               cnt++;
            end
         end
         pend = mem_req;
         paddr = mem_addr;
         pwe = mem_we;
         pdata = mem_wdata;
      end
   end

   // reference model: window pointer, resident count, pair stack
   int          m_cwp = 0;
   int          m_r = 1;
   logic [15:0] m_phys [8];
   logic [15:0] stk [$];

   task automatic load_phys();
      for (int i = 0; i < 8; i++) m_phys[i] = sc_arr[i];
      sc_en = 1'b1;
      @(negedge clk);
      #1 sc_en = 1'b0;
   endtask

   task automatic model_reset();
      m_cwp = 0;
      m_r = 1;
      stk.delete();
   endtask

   task automatic op(input bit c, input bit r_in);
      int kind;
      int n;
      int base;
      int x;
      int exp_lat;
      kind = 0;
      if (c) begin
         if (m_r < 3) kind = 0;
         else if (stk.size() / 2 < 16) kind = 1;
         else kind = 3;
      end else begin
         if (m_r > 1) kind = 0;
         else if (stk.size() > 0) kind = 2;
         else kind = 3;
      end
      exp_lat = (kind == 1) ? 4 : (kind == 2) ? 6 : 1;
      mem_seen = 1'b0;
      @(negedge clk);
      call_req = c;
      ret_req = r_in;
      @(negedge clk);
      call_req = 1'b0;
      ret_req = 1'b0;
      n = 1;
      if (kind == 1) begin
         chk("spill_sel", 32'(set_window), 32'd1);
         chk("spill_wnd", 32'(wnd), 32'((m_cwp + 2) % 4));
      end
      if (kind == 2) begin
         chk("fill_sel", 32'(set_window), 32'd1);
         chk("fill_wnd", 32'(wnd), 32'((m_cwp + 3) % 4));
      end
      while (!(done || err) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (kind == 3) begin
         chk("err_pulse", 32'(err), 32'd1);
         chk("err_nodone", 32'(done), 32'd0);
      end else begin
         chk("done", 32'(done), 32'd1);
         chk("no_err", 32'(err), 32'd0);
         if (lat == 0) chk("latency", 32'(n), 32'(exp_lat));
      end
      case (kind)
         0: begin
            m_cwp = c ? (m_cwp + 1) % 4 : (m_cwp + 3) % 4;
            m_r = c ? m_r + 1 : m_r - 1;
         end
         1: begin
            x = (m_cwp + 2) % 4;
            base = 128 + stk.size();
            stk.push_back(m_phys[2 * x]);
            stk.push_back(m_phys[2 * x + 1]);
            chk("spill_lo", 32'(mem[base]), 32'(m_phys[2 * x]));
            chk("spill_hi", 32'(mem[base + 1]), 32'(m_phys[2 * x + 1]));
            m_cwp = (m_cwp + 1) % 4;
         end
         2: begin
            x = (m_cwp + 3) % 4;
            m_phys[2 * x + 1] = stk.pop_back();
            m_phys[2 * x] = stk.pop_back();
            m_cwp = (m_cwp + 3) % 4;
         end
         default: ;
      endcase
      if (kind == 0 || kind == 3) chk("no_mem", 32'(mem_seen), 32'd0);
      @(negedge clk);
      chk("idle", 32'(busy), 32'd0);
      chk("cwp", 32'(cwp), 32'(m_cwp));
      if (kind == 2) begin
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("phys%0d", i), 32'(phys[i]), 32'(m_phys[i]));
            sc_arr[i] = phys[i];
         end
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("init_sel", 32'(set_window), 32'd1);
      chk("init_wnd", 32'(wnd), 32'd0);
      @(negedge clk);
      chk("init_done_sel", 32'(set_window), 32'd0);
      chk("init_busy", 32'(busy), 32'd0);
      chk("init_cwp", 32'(cwp), 32'd0);
   endtask

   initial begin
      int w;
      for (int i = 0; i < 8; i++) sc_arr[i] = 16'($urandom);
      sc_arr[0] = 16'hAAAA;
      sc_arr[1] = 16'h5555;
      #12;
      chk("rst_sel", 32'(set_window), 32'd1);
      chk("rst_wnd", 32'(wnd), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_we", 32'(rf_we), 32'd0);
      chk("rst_cwp", 32'(cwp), 32'd0);
      release_reset();
      load_phys();

      op(1, 0);
      op(1, 0);
      op(1, 0);
      chk("mem80", 32'(mem[8'h80]), 32'h0000AAAA);
      chk("mem81", 32'(mem[8'h81]), 32'h00005555);
      for (int i = 0; i < 8; i++) sc_arr[i] = phys[i];
      sc_arr[0] = 16'h0000;
      sc_arr[1] = 16'h0000;
      load_phys();
      op(0, 1);
      op(0, 1);
      op(0, 1);
      chk("fill_p0", 32'(phys[0]), 32'h0000AAAA);
      chk("fill_p1", 32'(phys[1]), 32'h00005555);
      op(0, 1);
      op(1, 1);

      op(1, 0);
      lat = 3;
      op(1, 0);
      lat = 10;
      @(negedge clk);
      call_req = 1'b1;
      @(negedge clk);
      call_req = 1'b0;
      w = 0;
      while (!mem_req && w < 10) begin
         @(negedge clk);
         w++;
      end
      chk("spill_started", 32'(mem_req), 32'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_req", 32'(mem_req), 32'd0);
      chk("abort_cwp", 32'(cwp), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      model_reset();
      for (int i = 0; i < 8; i++) sc_arr[i] = phys[i];
      release_reset();

      lat = 0;
      for (int i = 0; i < 19; i++) op(1, 0);
      for (int i = 0; i < 20; i++) op(0, 1);

      for (int k = 0; k < 150; k++) begin
         int sel;
         lat = int'($urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < 8; i++) sc_arr[i] = 16'($urandom);
            load_phys();
         end
         sel = int'($urandom_range(0, 9));
         if (sel < 5) op(1, 0);
         else if (sel < 9) op(0, 1);
         else op(1, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
